uart_mmio_ctrl: RTL



---
 rtl/uart_mmio_ctrl_if.sv | 28 ++
 rtl/uart_mmio_ctrl.sv | 137 +++++++++++++
 2 files changed

// File: rtl/uart_mmio_ctrl_if.sv
// Bundle of the CPU load/store signals and both UART byte handshakes.
// UART handshakes: a byte moves on a rising clk edge where valid and ready
// are both high; valid holds its byte stable until that edge.
interface uart_mmio_if;
  logic [31:0] addr;
  logic [31:0] din;
  logic [3:0]  wbe;
  logic        rd_en;
  logic [31:0] dout;
  logic [7:0]  data_out;
  logic        data_out_valid;
  logic        data_out_ready;
  logic [7:0]  data_in;
  logic        data_in_valid;
  logic        data_in_ready;

  modport slave (
    input  addr, din, wbe, rd_en,
    input  data_out, data_out_valid, data_in_ready,
    output dout, data_out_ready, data_in, data_in_valid
  );

  modport master (
    output addr, din, wbe, rd_en,
    output data_out, data_out_valid, data_in_ready,
    input  dout, data_out_ready, data_in, data_in_valid
  );
endinterface

// File: rtl/uart_mmio_ctrl.sv
// Memory-mapped UART controller: RX/TX byte FIFOs behind STATUS/CTRL, RX and
// TX data words, with sticky overflow flags and a one-cycle registered load path.
module uart_mmio_ctrl #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  uart_mmio_if.slave  bus
);

  localparam logic [31:0] ADDR_STAT = 32'h8000_0000;
  localparam logic [31:0] ADDR_RX   = 32'h8000_0004;
  localparam logic [31:0] ADDR_TX   = 32'h8000_0008;

  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  // Registered state
  logic [7:0]    rx_mem_q [DEPTH];
  logic [7:0]    tx_mem_q [DEPTH];
  logic [AW-1:0] rx_wr_ptr_q, rx_wr_ptr_d;
  logic [AW-1:0] rx_rd_ptr_q, rx_rd_ptr_d;
  logic [AW:0]   rx_cnt_q,    rx_cnt_d;
  logic [AW-1:0] tx_wr_ptr_q, tx_wr_ptr_d;
  logic [AW-1:0] tx_rd_ptr_q, tx_rd_ptr_d;
  logic [AW:0]   tx_cnt_q,    tx_cnt_d;
  logic          rx_ovf_q,    rx_ovf_d;
  logic          tx_ovf_q,    tx_ovf_d;
  logic [31:0]   dout_q,      dout_d;

  // Decode and FIFO status, all from pre-edge state
  logic        rx_empty, rx_full, tx_empty, tx_full;
  logic        wr_ctrl, wr_tx, rd_rx;
  logic        rx_push, rx_pop, tx_push, tx_pop;
  logic [31:0] status_w;
  logic        unused_bits;

  assign rx_empty = (rx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == CNT_FULL);
  assign tx_empty = (tx_cnt_q == '0);
  assign tx_full  = (tx_cnt_q == CNT_FULL);

  assign wr_ctrl = bus.wbe[0] && (bus.addr == ADDR_STAT);
  assign wr_tx   = bus.wbe[0] && (bus.addr == ADDR_TX);
  assign rd_rx   = bus.rd_en  && (bus.addr == ADDR_RX);

  assign rx_push = bus.data_out_valid && !rx_full;
  assign rx_pop  = rd_rx && !rx_empty;
  // A TX write on a full FIFO is dropped even if the UART pops on the same edge.
  assign tx_push = wr_tx && !tx_full;
  assign tx_pop  = !tx_empty && bus.data_in_ready;

  assign status_w = {8'h00, 8'(tx_cnt_q), 8'(rx_cnt_q),
                     4'h0, tx_ovf_q, rx_ovf_q, !rx_empty, !tx_full};

  assign bus.data_out_ready = !rx_full;
  assign bus.data_in_valid  = !tx_empty;
  assign bus.data_in        = tx_empty ? 8'h00 : tx_mem_q[tx_rd_ptr_q];
  assign bus.dout           = dout_q;

  assign unused_bits = ^{bus.din[31:8], bus.wbe[3:1]};

  always_comb begin
    rx_wr_ptr_d = rx_wr_ptr_q;
    rx_rd_ptr_d = rx_rd_ptr_q;
    rx_cnt_d    = rx_cnt_q;
    tx_wr_ptr_d = tx_wr_ptr_q;
    tx_rd_ptr_d = tx_rd_ptr_q;
    tx_cnt_d    = tx_cnt_q;
    rx_ovf_d    = rx_ovf_q;
    tx_ovf_d    = tx_ovf_q;
    dout_d      = dout_q;

    if (rx_push) rx_wr_ptr_d = rx_wr_ptr_q + PTR_ONE;
    if (rx_pop)  rx_rd_ptr_d = rx_rd_ptr_q + PTR_ONE;
    case ({rx_push, rx_pop})
      2'b10:   rx_cnt_d = rx_cnt_q + CNT_ONE;
      2'b01:   rx_cnt_d = rx_cnt_q - CNT_ONE;
      default: rx_cnt_d = rx_cnt_q;
    endcase

    if (tx_push) tx_wr_ptr_d = tx_wr_ptr_q + PTR_ONE;
    if (tx_pop)  tx_rd_ptr_d = tx_rd_ptr_q + PTR_ONE;
    case ({tx_push, tx_pop})
      2'b10:   tx_cnt_d = tx_cnt_q + CNT_ONE;
      2'b01:   tx_cnt_d = tx_cnt_q - CNT_ONE;
      default: tx_cnt_d = tx_cnt_q;
    endcase

    // A CTRL clear wins over an overflow raised on the same edge.
    if (wr_ctrl && bus.din[2])                 rx_ovf_d = 1'b0;
    else if (bus.data_out_valid && rx_full)    rx_ovf_d = 1'b1;
    if (wr_ctrl && bus.din[3])                 tx_ovf_d = 1'b0;
    else if (wr_tx && tx_full)                 tx_ovf_d = 1'b1;

    if (bus.rd_en) begin
      case (bus.addr)
        ADDR_STAT: dout_d = status_w;
        ADDR_RX:   dout_d = rx_empty ? 32'h0 : {24'h0, rx_mem_q[rx_rd_ptr_q]};
        default:   dout_d = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_cnt_q    <= '0;
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_cnt_q    <= '0;
      rx_ovf_q    <= 1'b0;
      tx_ovf_q    <= 1'b0;
      dout_q      <= 32'h0;
    end else begin
      rx_wr_ptr_q <= rx_wr_ptr_d;
      rx_rd_ptr_q <= rx_rd_ptr_d;
      rx_cnt_q    <= rx_cnt_d;
      tx_wr_ptr_q <= tx_wr_ptr_d;
      tx_rd_ptr_q <= tx_rd_ptr_d;
      tx_cnt_q    <= tx_cnt_d;
      rx_ovf_q    <= rx_ovf_d;
      tx_ovf_q    <= tx_ovf_d;
      dout_q      <= dout_d;
    end
  end

  // Storage arrays need no reset: the pointers and counts define validity.
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem_q[rx_wr_ptr_q] <= bus.data_out;
    if (tx_push) tx_mem_q[tx_wr_ptr_q] <= bus.din[7:0];
  end

endmodule
